axi_mem_arb: RTL and testbench

AXI_MEM_ARB -- requirements
Module: axi_mem_arb

---
 rtl/axi_mem_arb.sv | 137 +++++++++++++
 tb/tb_axi_mem_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arb.sv
// ---------------------------------------------------------------------------
// axi_mem_arb
//   Two-requester arbiter that shares one bridge request port between the
//   instruction-fetch side and the load/store side. Three-state FSM
//   (IDLE -> REQ -> DATA), at most one transaction outstanding.
//
//   Default policy: data wins a tie unless it has been granted STARVE_MAX
//   times in a row while inst was waiting; then inst is forced through.
//   Optional feature macro ARB_RR_EN: ties alternate on a last-owner bit and
//   the starvation counter is not built.
//
// Ports
//   aclk, aresetn                  clock, asynchronous active-low reset
//   inst_req/inst_addr             fetch request (always word read)
//   inst_addr_ok/inst_data_ok      fetch handshake pulses
//   data_req/wr/size/addr/wdata    load/store request
//   data_addr_ok/data_data_ok      load/store handshake pulses
//   rdata                          shared read data, zero unless a data_ok
//   mem_req/wr/size/addr/wdata     shared request port to the bridge
//   mem_addr_ok/mem_data_ok        bridge handshake
//   mem_rdata                      bridge read data
// ---------------------------------------------------------------------------
module axi_mem_arb #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t r_state;
    logic   r_owner;          // 0 = inst, 1 = data
    logic   w_grant_data;
    logic   w_in_req;
    logic   w_in_data;

`ifdef ARB_RR_EN
    logic r_last;             // owner of the most recent grant

    // On a tie the requester that was not served last wins.
    assign w_grant_data = data_req && (!inst_req || !r_last);
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] r_starve;

    // Data wins a tie until inst has watched STARVE_LIM data grants go by.
    assign w_grant_data = data_req && (!inst_req || (r_starve != STARVE_LIM));
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
`ifdef ARB_RR_EN
            r_last   <= 1'b0;
`else
            r_starve <= 4'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // the pre-edge values, so the grant and the counter update use
            // the same r_starve regardless of statement order.
            case (r_state)
                S_IDLE: begin
                    if (inst_req || data_req) begin
                        r_owner <= w_grant_data;
                        r_state <= S_REQ;
`ifdef ARB_RR_EN
                        r_last  <= w_grant_data;
`else
                        if (!w_grant_data) begin
                            r_starve <= 4'd0;
                        end else if (inst_req && (r_starve != STARVE_LIM)) begin
                            r_starve <= r_starve + 4'd1;
                        end
`endif
                    end
                end
                S_REQ: begin
                    if (mem_addr_ok) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (mem_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_in_req  = (r_state == S_REQ);
    assign w_in_data = (r_state == S_DATA);

    // Request fields follow the owner's live inputs; fetches are word reads.
    assign mem_req   = w_in_req;
    assign mem_wr    = r_owner ? data_wr    : 1'b0;
    assign mem_size  = r_owner ? data_size  : 2'd2;
    assign mem_addr  = r_owner ? data_addr  : inst_addr;
    assign mem_wdata = r_owner ? data_wdata : 32'h0;

    // Handshake pulses are same-cycle pass-throughs gated by state, so a
    // bridge strobe in the wrong state never reaches either requester.
    assign inst_addr_ok = w_in_req  && mem_addr_ok && !r_owner;
    assign data_addr_ok = w_in_req  && mem_addr_ok &&  r_owner;
    assign inst_data_ok = w_in_data && mem_data_ok && !r_owner;
    assign data_data_ok = w_in_data && mem_data_ok &&  r_owner;
    assign rdata        = (w_in_data && mem_data_ok) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_axi_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_arb
//   Directed bench for axi_mem_arb. Inputs change just after the falling
//   edge, outputs are sampled 1 ns later, well away from the rising edge.
//   Build with ARB_RR_EN defined to match a round-robin DUT build.
// ---------------------------------------------------------------------------
module tb_axi_mem_arb;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_0010;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_bad = 0;

    // Results captured by run_txn.
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [1:0]  t_size;
    logic        t_wr, t_iaok, t_daok, t_idok, t_ddok, t_to;

    always #5 aclk = ~aclk;

    axi_mem_arb dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .rdata(rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(negedge aclk);
    endtask

    // Bridge that accepts the address in the first REQ cycle and returns
    // data in the first DATA cycle. Waits for mem_req within a budget.
    task automatic run_txn(input logic [31:0] rd);
        int n = 0;
        t_to = 1'b0;
        forever begin
            step();
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b0;
            #1;
            if (mem_req === 1'b1) break;
            n++;
            if (n > 20) begin
                t_to = 1'b1;
                return;
            end
        end
        t_addr = mem_addr; t_wr = mem_wr; t_size = mem_size; t_wdata = mem_wdata;
        mem_addr_ok = 1'b1;
        #1;
        t_iaok = inst_addr_ok; t_daok = data_addr_ok;
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        #1;
        t_idok = inst_data_ok; t_ddok = data_data_ok; t_rdata = rdata;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step(); step(); #1;
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset mem_req got %b want 0", mem_req); end
        n_vec++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'b0) begin
            n_bad++; $display("FAIL reset oks got %b want 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset rdata got %h want 0", rdata); end
        inst_req = 1'b0; data_req = 1'b0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        step();
        aresetn = 1'b1;
        #1;
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_release mem_req got %b want 0", mem_req); end
    endtask

    task automatic test_inst_only();
        // cycle 0: request in IDLE
        step(); inst_req = 1'b1; inst_addr = IA; #1;
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL inst_c0 mem_req got %b want 0", mem_req); end
        // cycle 1: REQ, bridge not ready yet
        step(); #1;
        n_vec++; if ({mem_req, mem_wr, mem_size} !== 4'b1010) begin
            n_bad++; $display("FAIL inst_c1 req/wr/size got %b want 1010", {mem_req, mem_wr, mem_size}); end
        n_vec++; if (mem_addr !== IA) begin n_bad++; $display("FAIL inst_c1 mem_addr got %h want %h", mem_addr, IA); end
        n_vec++; if (inst_addr_ok !== 1'b0) begin n_bad++; $display("FAIL inst_c1 addr_ok got %b want 0", inst_addr_ok); end
        // cycle 2: address accepted
        step(); mem_addr_ok = 1'b1; #1;
        n_vec++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            n_bad++; $display("FAIL inst_c2 addr_ok i/d got %b want 10", {inst_addr_ok, data_addr_ok}); end
        // cycle 3: DATA, waiting
        step(); mem_addr_ok = 1'b0; inst_req = 1'b0; #1;
        n_vec++; if ({mem_req, inst_data_ok} !== 2'b00) begin
            n_bad++; $display("FAIL inst_c3 req/data_ok got %b want 00", {mem_req, inst_data_ok}); end
        // cycle 4: data returned
        step(); mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; #1;
        n_vec++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            n_bad++; $display("FAIL inst_c4 data_ok i/d got %b want 10", {inst_data_ok, data_data_ok}); end
        n_vec++; if (rdata !== 32'h2408_0001) begin n_bad++; $display("FAIL inst_c4 rdata got %h want 24080001", rdata); end
        // cycle 5: back in IDLE
        step(); mem_data_ok = 1'b0; #1;
        n_vec++; if ({mem_req, rdata} !== 33'h0) begin n_bad++; $display("FAIL inst_c5 idle got req=%b rdata=%h want 0/0", mem_req, rdata); end
    endtask

    task automatic test_both();
        inst_req = 1'b1; inst_addr = IA + 32'h4;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1;
        data_addr = DA; data_wdata = 32'h1234_5678;
        run_txn(32'h0);
        n_vec++; if (t_to !== 1'b0) begin n_bad++; $display("FAIL both_1 timeout got 1 want 0"); end
        n_vec++; if ({t_addr, t_wr, t_size} !== {DA, 1'b1, 2'd1}) begin
            n_bad++; $display("FAIL both_1 addr/wr/size got %h/%b/%0d want %h/1/1", t_addr, t_wr, t_size, DA); end
        n_vec++; if (t_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL both_1 wdata got %h want 12345678", t_wdata); end
        n_vec++; if ({t_iaok, t_daok, t_idok, t_ddok} !== 4'b0101) begin
            n_bad++; $display("FAIL both_1 oks got %b want 0101", {t_iaok, t_daok, t_idok, t_ddok}); end
        data_req = 1'b0;
        run_txn(32'hCAFE_0001);
        n_vec++; if (t_to !== 1'b0) begin n_bad++; $display("FAIL both_2 timeout got 1 want 0"); end
        n_vec++; if ({t_addr, t_wr, t_size} !== {IA + 32'h4, 1'b0, 2'd2}) begin
            n_bad++; $display("FAIL both_2 addr/wr/size got %h/%b/%0d want %h/0/2", t_addr, t_wr, t_size, IA + 32'h4); end
        n_vec++; if ({t_iaok, t_daok, t_idok, t_ddok, t_rdata} !== {4'b1010, 32'hCAFE_0001}) begin
            n_bad++; $display("FAIL both_2 oks/rdata got %b/%h want 1010/cafe0001", {t_iaok, t_daok, t_idok, t_ddok}, t_rdata); end
        inst_req = 1'b0;
    endtask

    // Grant order with both requesters held; 1 = data granted.
    task automatic test_starvation();
`ifdef ARB_RR_EN
        logic [9:0] exp = 10'b0101010101;
`else
        logic [9:0] exp = 10'b0111101111;
`endif
        inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
        for (int i = 0; i < 10; i++) begin
            run_txn(32'(i));
            n_vec++; if (t_to !== 1'b0 || (t_addr === DA) !== exp[i]) begin
                n_bad++; $display("FAIL starve_%0d owner_data got %b want %b (timeout %b)", i, t_addr === DA, exp[i], t_to); end
        end
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_spurious();
        step(); mem_data_ok = 1'b0; data_req = 1'b1; data_wr = 1'b0; data_addr = DA + 32'h8; #1;
        // REQ with a stray data strobe
        step(); mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
        n_vec++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b10000) begin
            n_bad++; $display("FAIL spur_req got %b want 10000", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        n_vec++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL spur_req rdata got %h want 0", rdata); end
        // still REQ: real address accept
        step(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; #1;
        n_vec++; if ({mem_req, data_addr_ok, inst_addr_ok} !== 3'b110) begin
            n_bad++; $display("FAIL spur_accept got %b want 110", {mem_req, data_addr_ok, inst_addr_ok}); end
        // DATA with a stray address strobe
        step(); data_req = 1'b0; #1;
        n_vec++; if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b00000) begin
            n_bad++; $display("FAIL spur_data got %b want 00000", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        // still DATA: real data return
        step(); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_F00D; #1;
        n_vec++; if ({data_data_ok, inst_data_ok, rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            n_bad++; $display("FAIL spur_done got %b/%h want 10/0badf00d", {data_data_ok, inst_data_ok}, rdata); end
        step(); mem_data_ok = 1'b0;
    endtask

    task automatic test_reset_mid();
`ifdef ARB_RR_EN
        logic [4:0] exp = 5'b10101;
`else
        logic [4:0] exp = 5'b01111;
`endif
        // Build up some arbitration history.
        inst_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 3; i++) run_txn(32'h0);
        inst_req = 1'b0;
        step(); mem_data_ok = 1'b0; data_addr = DA; #1;   // IDLE, data only
        step(); mem_addr_ok = 1'b1; #1;                   // REQ, accepted
        step(); mem_addr_ok = 1'b0; data_req = 1'b0; #1;  // DATA
        step(); aresetn = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h7777_7777; #1;
        n_vec++; if ({data_data_ok, inst_data_ok, mem_req, rdata} !== 35'h0) begin
            n_bad++; $display("FAIL rmid_pulse got %b rdata %h want 000/0", {data_data_ok, inst_data_ok, mem_req}, rdata); end
        step(); aresetn = 1'b1; mem_data_ok = 1'b0; #1;
        n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rmid_idle mem_req got %b want 0", mem_req); end
        // Fresh history after reset: order reflects a cleared counter.
        inst_req = 1'b1; data_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_txn(32'h0);
            n_vec++; if (t_to !== 1'b0 || (t_addr === DA) !== exp[i]) begin
                n_bad++; $display("FAIL rmid_grant_%0d owner_data got %b want %b (timeout %b)", i, t_addr === DA, exp[i], t_to); end
        end
        inst_req = 1'b0; data_req = 1'b0;
        step(); mem_data_ok = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        inst_req = 1'b0; inst_addr = 32'h0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
        data_addr = 32'h0; data_wdata = 32'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        t_to = 1'b0;
        test_reset();
        test_inst_only();
        test_both();
        test_starvation();
        test_spurious();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
